timer_rd_regs: RTL and testbench
================================

// Module: timer_rd_regs
// PURPOSE
//  Timer register bank: the write-enable target of the 2-bit write-address
//  decoder, plus the read-back path and the timer core it controls.
//  - Writes arrive as one-hot per-register enables; reads are a registered
//    read port with a valid pulse.
//  - Prescaled down-counter with auto-reload, sticky expire flag and a
//    level interrupt.
//  - Sits between the bus/register-access logic and system interrupt logic.
// PARAMETERS
//  DW       16   register/data width (CTRL uses bits [2:0], STATUS bit 0)
//  PRESCALE 100  clocks per count tick; legal >= 1; prescaler width $clog2(PRESCALE)
// PORTS
//  i_clk      in   1   clock, all state on rising edge
//  i_rst_n    in   1   asynchronous active-low reset
//  i_wr_en    in   4   one-hot write enables: [0] CTRL, [1] LOAD, [2] STATUS; [3] ignored
//  i_wdata    in   DW  write data, sampled when any i_wr_en bit is high
//  i_rd_en    in   1   read request, one cycle per read
//  i_rd_addr  in   2   read address: 00 CTRL, 01 LOAD, 10 STATUS, 11 COUNT
//  o_rd_data  out  DW  read data, valid with o_rd_valid, held until next read
//  o_rd_valid out  1   one-cycle pulse, 1 clock after i_rd_en
//  o_irq      out  1   registered: STATUS.expired & CTRL.irq_en
// BEHAVIOUR
//  Reset (async, i_rst_n=0)
//   - All registers, prescaler, o_rd_data, o_rd_valid and o_irq = 0.
//   - Mid-operation reset aborts the count and any pending read pulse.
//  Register map (addr: name, fields)
//   - 00 CTRL: [0] en, [1] auto_reload, [2] irq_en; R/W.
//   - 01 LOAD: [DW-1:0]; R/W. Every write also copies i_wdata into COUNT.
//   - 10 STATUS: [0] expired; write-1-to-clear.
//   - 11 COUNT: read-only; unused bits read 0.
//  Write timing
//   - Takes effect on the clock edge where the enable is high.
//   - More than one i_wr_en bit high: each enabled register is written.
//  Prescaler
//   - en=0: prescaler held at 0.
//   - en=1: counts 0..PRESCALE-1 and wraps; tick = 1-cycle pulse at PRESCALE-1.
//   - Writing CTRL with en 0->1 clears the prescaler, so the first tick comes
//     PRESCALE clocks later.
//  Count on tick
//   - COUNT!=0: COUNT <= COUNT-1.
//   - COUNT==0: expired <= 1, then
//     - auto_reload=1: COUNT <= LOAD.
//     - auto_reload=0: en <= 0 and COUNT stays 0.
//   - LOAD=0 with en=1: expires on every tick (auto_reload=1) or on the first tick.
//  Simultaneous events
//   - LOAD write and tick in the same cycle: the LOAD write wins for COUNT.
//   - CTRL write and a one-shot auto-clear of en: the CTRL write wins.
//   - W1C and expire in the same cycle: expire (set) wins.
//  Read port
//   - i_rd_en at edge N: o_rd_data = register value before edge N updates;
//     o_rd_valid = 1 for the cycle after N.
//   - Back-to-back reads are allowed, one per cycle.
//   - A read never modifies state.
//  o_irq
//   - Updated 1 clock after expired/irq_en change.
//   - Cleared 1 clock after STATUS W1C or irq_en=0.
// TESTING (bench uses PRESCALE=4, DW=16)
//  1. Reset, then read each address: o_rd_data=0 and o_rd_valid pulses 1 cycle
//     after each i_rd_en.
//  2. One-shot: LOAD=3, CTRL=3'b101.
//     -> COUNT 3,2,1,0 every 4 clocks.
//     -> Expires at tick 4 (clock 16 after enable); en reads 0; o_irq=1 next cycle.
//  3. Auto-reload: LOAD=2, CTRL=3'b011.
//     -> COUNT 2,1,0,2,1,0...; expired set at each zero tick.
//     -> Clearing via W1C while running returns STATUS=0 until the next expire.
//  4. W1C on STATUS in the same cycle as an expire tick -> STATUS reads 1.
//  5. LOAD write of 9 coinciding with a tick -> COUNT reads 9, not LOAD-1 or
//     old COUNT-1.
//  6. Assert i_rst_n=0 mid-count with o_irq=1 -> all outputs 0 immediately;
//     after release COUNT=0 and en=0.

Source files
------------

// File: rtl/timer_rd_regs.sv
// Timer register bank: one-hot write enables, registered read port with a valid
// pulse, and a prescaled down-counter with auto-reload, sticky expire flag and irq.
module timer_rd_regs #(
  parameter int DW       = 16,
  parameter int PRESCALE = 100
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [3:0]    i_wr_en,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd_en,
  input  logic [1:0]    i_rd_addr,
  output logic [DW-1:0] o_rd_data,
  output logic          o_rd_valid,
  output logic          o_irq
);

  // A prescale of 1 still needs a 1-bit counter; it just never leaves 0.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [2:0]    ctrl_reg,    ctrl_next;
  logic [DW-1:0] load_reg,    load_next;
  logic [DW-1:0] count_reg,   count_next;
  logic          expired_reg, expired_next;
  logic [PW-1:0] presc_reg,   presc_next;
  logic          tick;
  logic          zero_tick;
  logic [DW-1:0] rd_mux;

  always_comb begin
    ctrl_next    = ctrl_reg;
    load_next    = load_reg;
    count_next   = count_reg;
    expired_next = expired_reg;
    presc_next   = presc_reg;

    tick      = ctrl_reg[0] && (presc_reg == PRE_LAST);
    zero_tick = tick && (count_reg == '0);

    // Ordering below sets priority: W1C < expire, one-shot stop < CTRL write,
    // tick decrement/reload < LOAD write.
    if (i_wr_en[2] && i_wdata[0]) begin
      expired_next = 1'b0;
    end

    if (zero_tick) begin
      expired_next = 1'b1;
      if (ctrl_reg[1]) begin
        count_next = load_reg;
      end else begin
        ctrl_next[0] = 1'b0;
      end
    end else if (tick) begin
      count_next = count_reg - DW'(1);
    end

    if (i_wr_en[0]) begin
      ctrl_next = i_wdata[2:0];
    end

    if (i_wr_en[1]) begin
      load_next  = i_wdata;
      count_next = i_wdata;
    end

    if (!ctrl_next[0]) begin
      presc_next = '0;
    end else if (i_wr_en[0] && !ctrl_reg[0]) begin
      presc_next = '0;
    end else if (presc_reg == PRE_LAST) begin
      presc_next = '0;
    end else begin
      presc_next = presc_reg + PW'(1);
    end
  end

  always_comb begin
    rd_mux = '0;
    case (i_rd_addr)
      2'b00:   rd_mux[2:0] = ctrl_reg;
      2'b01:   rd_mux      = load_reg;
      2'b10:   rd_mux[0]   = expired_reg;
      default: rd_mux      = count_reg;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ctrl_reg    <= '0;
      load_reg    <= '0;
      count_reg   <= '0;
      expired_reg <= 1'b0;
      presc_reg   <= '0;
      o_rd_data   <= '0;
      o_rd_valid  <= 1'b0;
      o_irq       <= 1'b0;
    end else begin
      ctrl_reg    <= ctrl_next;
      load_reg    <= load_next;
      count_reg   <= count_next;
      expired_reg <= expired_next;
      presc_reg   <= presc_next;
      o_rd_valid  <= i_rd_en;
      if (i_rd_en) begin
        o_rd_data <= rd_mux;
      end
      o_irq       <= expired_reg & ctrl_reg[2];
    end
  end

endmodule

// File: tb/tb_timer_rd_regs.sv
// Directed bench for timer_rd_regs: reads push expectations into a scoreboard
// queue, a monitor pops and compares on every o_rd_valid.
module tb_timer_rd_regs;

  localparam int DW = 16;
  localparam int PRESCALE = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    wr_en = '0;
  logic [DW-1:0] wdata = '0;
  logic          rd_en = 1'b0;
  logic [1:0]    rd_addr = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          irq;

  timer_rd_regs #(.DW(DW), .PRESCALE(PRESCALE)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_wr_en    (wr_en),
    .i_wdata    (wdata),
    .i_rd_en    (rd_en),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_rd_valid (rd_valid),
    .o_irq      (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  localparam int A_CTRL = 0, A_LOAD = 1, A_STATUS = 2, A_COUNT = 3;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every valid pulse must match the oldest outstanding read, on time.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rd_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_valid: rd_valid=1 data=%0h at cycle %0d, required no pulse", rd_data, cyc);
      end else begin
        e = exp_q.pop_front();
        if (rd_data !== e.data || cyc != e.due) begin
          n_fail++;
          $display("FAIL %s: data=%0h cycle=%0d, required data=%0h cycle=%0d", e.name, rd_data, cyc, e.data, e.due);
        end else begin
          $display("read %s: data=%0h cycle=%0d ok", e.name, rd_data, cyc);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      n_checks++;
      n_fail++;
      $display("FAIL %s: no rd_valid at cycle %0d, required data=%0h", e.name, cyc, e.data);
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end else begin
      $display("check %s: %0h ok", nm, act);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int idx, input logic [DW-1:0] d);
    wr_en = 4'(1 << idx);
    wdata = d;
    @(negedge clk);
    wr_en = '0;
    wdata = '0;
  endtask

  task automatic rd(input int a, input logic [DW-1:0] req, input string nm);
    exp_t e;
    e.data = req;
    e.due  = cyc + 1;
    e.name = nm;
    exp_q.push_back(e);
    rd_en   = 1'b1;
    rd_addr = 2'(a);
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1. reset state
    idle(3);
    chk("reset_irq", DW'(irq), 0);
    chk("reset_valid", DW'(rd_valid), 0);
    rst_n = 1'b1;
    idle(1);
    rd(A_CTRL, 16'h0, "rst_ctrl");
    rd(A_LOAD, 16'h0, "rst_load");
    rd(A_STATUS, 16'h0, "rst_status");
    rd(A_COUNT, 16'h0, "rst_count");
    idle(2);

    // 2. one-shot, LOAD=3, CTRL=en|irq_en; enable edge is E0
    wr(A_LOAD, 16'd3);
    wr(A_CTRL, 16'h5);
    rd(A_COUNT, 16'd3, "os_count3");      // E1
    idle(3);
    rd(A_COUNT, 16'd2, "os_count2");      // E5
    idle(3);
    rd(A_COUNT, 16'd1, "os_count1");      // E9
    idle(3);
    rd(A_COUNT, 16'd0, "os_count0");      // E13
    rd(A_STATUS, 16'd0, "os_status_pre"); // E14
    rd(A_CTRL, 16'h5, "os_ctrl_pre");     // E15
    idle(1);                              // E16 expires
    chk("os_irq_latency", DW'(irq), 0);
    rd(A_STATUS, 16'd1, "os_status_exp"); // E17
    chk("os_irq", DW'(irq), 1);
    rd(A_CTRL, 16'h4, "os_ctrl_en_cleared");
    rd(A_COUNT, 16'd0, "os_count_exp");
    idle(8);
    rd(A_COUNT, 16'd0, "os_count_stopped");

    // 3. auto-reload, LOAD=2, CTRL=en|auto_reload; enable edge is E0
    wr(A_CTRL, 16'h0);
    wr(A_STATUS, 16'h1);
    chk("ar_irq_cleared", DW'(irq), 0);
    wr(A_LOAD, 16'd2);
    wr(A_CTRL, 16'h3);
    rd(A_COUNT, 16'd2, "ar_count2");      // E1
    idle(3);
    rd(A_COUNT, 16'd1, "ar_count1");      // E5
    idle(3);
    rd(A_COUNT, 16'd0, "ar_count0");      // E9
    rd(A_STATUS, 16'd0, "ar_status_pre"); // E10
    idle(2);                              // E12 expires and reloads
    rd(A_STATUS, 16'd1, "ar_status_exp"); // E13
    rd(A_COUNT, 16'd2, "ar_reload");      // E14
    wr(A_STATUS, 16'h1);                  // E15 W1C
    rd(A_STATUS, 16'd0, "ar_status_w1c"); // E16
    rd(A_COUNT, 16'd1, "ar_count1b");     // E17
    idle(6);
    rd(A_STATUS, 16'd0, "ar_status_still0"); // E24, expires on this edge
    rd(A_STATUS, 16'd1, "ar_status_exp2");   // E25
    rd(A_COUNT, 16'd2, "ar_reload2");        // E26
    chk("ar_irq_disabled", DW'(irq), 0);

    // 4. W1C in the same cycle as an expire tick (E36)
    idle(9);
    wr(A_STATUS, 16'h1);                     // E36
    rd(A_STATUS, 16'd1, "w1c_vs_expire");    // E37
    rd(A_COUNT, 16'd2, "w1c_reload");        // E38

    // 5. LOAD write coinciding with a tick (E40)
    idle(1);
    wr(A_LOAD, 16'd9);                       // E40
    rd(A_COUNT, 16'd9, "load_vs_tick");      // E41
    rd(A_LOAD, 16'd9, "load_value");         // E42
    idle(2);                                 // E44 tick
    rd(A_COUNT, 16'd8, "load_then_dec");     // E45

    // 6. reset mid-count with irq asserted
    wr(A_CTRL, 16'h7);                       // E46
    idle(1);
    chk("irq_before_reset", DW'(irq), 1);
    rd(A_LOAD, 16'd9, "read_before_reset");
    rst_n = 1'b0;
    #1;
    chk("rst_irq", DW'(irq), 0);
    chk("rst_rd_valid", DW'(rd_valid), 0);
    chk("rst_rd_data", rd_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(A_COUNT, 16'd0, "post_rst_count");
    rd(A_CTRL, 16'd0, "post_rst_ctrl");
    rd(A_STATUS, 16'd0, "post_rst_status");
    idle(3);
    chk("post_rst_irq", DW'(irq), 0);
    chk("scoreboard_drained", DW'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
